// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: shared FSM states, drain-counter width helper and verdict codes
package sim_monitor_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  localparam logic [1:0] VERDICT_PASS = 2'd0;
  localparam logic [1:0] VERDICT_FAIL = 2'd1;
  localparam logic [1:0] VERDICT_TIMEOUT = 2'd2;
  function automatic int drain_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
  function automatic logic [1:0] verdict(input logic timeout, input logic pass);
    return timeout ? VERDICT_TIMEOUT : pass ? VERDICT_PASS : VERDICT_FAIL;
  endfunction
endpackage

// File: rtl/sim_event_counter.sv
// sim_event_counter: saturating event counter with synchronous clear and freeze
module sim_event_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  input  logic         freeze,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (clear) count <= '0;
    else if (inc && !freeze && count != '1) count <= count + W'(1);
endmodule

// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor: end-of-run monitor latching a pass/fail/timeout verdict after a drain window
module sim_halt_monitor
  import sim_monitor_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 64,
  parameter int MAX_CYCLES   = 10_000_000,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_ebreak,
  input  logic [XLEN-1:0]  io_a0,
  input  logic             io_retire,
  output logic             io_done,
  output logic             io_pass,
  output logic             io_timeout,
  output logic [XLEN-1:0]  io_exit_code,
  output logic [CNT_W-1:0] io_cycles,
  output logic [CNT_W-1:0] io_instrs
);
  localparam int DW = drain_w(DRAIN_CYCLES);
  localparam int BW = $clog2(MAX_CYCLES + 1);
  state_t state, state_d;
  logic [DW-1:0] drain_cnt;
  // budget is tracked apart from io_cycles, which may saturate before the budget ends
  logic [BW-1:0] budget;
  logic expire;
  always_comb begin
    expire = budget == BW'(MAX_CYCLES - 1);
    state_d = state == RUN ? ((io_ebreak || expire) ? DRAIN : RUN)
            : state == DRAIN ? (drain_cnt == '0 ? DONE : DRAIN) : DONE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= RUN;
      drain_cnt <= '0;
      budget <= '0;
      io_exit_code <= '0;
      io_timeout <= 1'b0;
      io_done <= 1'b0;
      io_pass <= 1'b0;
    end else begin
      state <= state_d;
      if (state == RUN) begin
        budget <= budget + BW'(1);
        drain_cnt <= DW'(DRAIN_CYCLES);
        if (io_ebreak) io_exit_code <= io_a0;
        else if (expire) begin
          io_timeout <= 1'b1;
          io_exit_code <= '0;
        end
      end
      if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
      if (state == DRAIN && drain_cnt == '0) begin
        io_done <= 1'b1;
        io_pass <= !io_timeout && io_exit_code == '0;
      end
    end
  sim_event_counter #(.W(CNT_W)) u_cycles (
    .clk(clock), .clear(reset), .inc(1'b1), .freeze(state != RUN), .count(io_cycles)
  );
  sim_event_counter #(.W(CNT_W)) u_instrs (
    .clk(clock), .clear(reset), .inc(io_retire), .freeze(state != RUN), .count(io_instrs)
  );
endmodule

// File: tb/tb_sim_halt_monitor.sv
// tb_sim_halt_monitor: scoreboard bench driving three monitor configurations from one trace
module tb_sim_halt_monitor;
  import sim_monitor_pkg::*;
  typedef struct {
    logic [63:0] cyc;
    logic [63:0] ins;
    logic [31:0] exit_code;
    logic        to;
    logic        pass;
    int          lat;
  } exp_t;
  logic clock = 0, reset = 1, ebreak = 0, retire = 0;
  logic [31:0] a0 = 0;
  always #5 clock = ~clock;
  logic done_a, pass_a, to_a, done_b, pass_b, to_b, done_c, pass_c, to_c;
  logic [31:0] exit_a, exit_b, exit_c;
  logic [63:0] cyc_a, ins_a, cyc_b, ins_b;
  logic [3:0] cyc_c, ins_c;
  sim_halt_monitor dut_a (
    .clock(clock), .reset(reset), .io_ebreak(ebreak), .io_a0(a0), .io_retire(retire),
    .io_done(done_a), .io_pass(pass_a), .io_timeout(to_a), .io_exit_code(exit_a),
    .io_cycles(cyc_a), .io_instrs(ins_a)
  );
  sim_halt_monitor #(.MAX_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset), .io_ebreak(ebreak), .io_a0(a0), .io_retire(retire),
    .io_done(done_b), .io_pass(pass_b), .io_timeout(to_b), .io_exit_code(exit_b),
    .io_cycles(cyc_b), .io_instrs(ins_b)
  );
  sim_halt_monitor #(.CNT_W(4), .MAX_CYCLES(40), .DRAIN_CYCLES(0)) dut_c (
    .clock(clock), .reset(reset), .io_ebreak(ebreak), .io_a0(a0), .io_retire(retire),
    .io_done(done_c), .io_pass(pass_c), .io_timeout(to_c), .io_exit_code(exit_c),
    .io_cycles(cyc_c), .io_instrs(ins_c)
  );
  bit eb_t[256];
  bit ret_t[256];
  logic [31:0] a0_t[256];
  int len;
  exp_t q_a[$], q_b[$], q_c[$];
  int errors = 0, checks = 0, edge_n = 0;
  bit seen_a, seen_b, seen_c;
  always @(posedge clock) edge_n <= reset ? 0 : edge_n + 1;
  // Reference: the run ends at the first ebreak inside the budget, otherwise at the last budget cycle.
  function automatic exp_t model(int max_c, int drain, int cw);
    exp_t e;
    int stop;
    logic [63:0] sat;
    stop = max_c - 1;
    e.to = 1;
    e.exit_code = 0;
    for (int i = 0; i < max_c && i < 256; i++)
      if (eb_t[i]) begin
        stop = i;
        e.to = 0;
        e.exit_code = a0_t[i];
        break;
      end
    e.cyc = 64'(stop + 1);
    e.ins = 0;
    for (int i = 0; i <= stop; i++) e.ins += 64'(ret_t[i]);
    sat = (cw >= 64) ? '1 : (64'd1 << cw) - 64'd1;
    if (e.cyc > sat) e.cyc = sat;
    if (e.ins > sat) e.ins = sat;
    e.pass = !e.to && e.exit_code == 0;
    e.lat = stop + 2 + drain;
    return e;
  endfunction
  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_done(string id, exp_t e, logic pass, logic to, logic [31:0] ex,
                            logic [63:0] cyc, logic [63:0] ins);
    cmp({id, " done latency"}, 64'(edge_n), 64'(e.lat));
    cmp({id, " cycles"}, cyc, e.cyc);
    cmp({id, " instrs"}, ins, e.ins);
    cmp({id, " exit_code"}, 64'(ex), 64'(e.exit_code));
    cmp({id, " timeout"}, 64'(to), 64'(e.to));
    cmp({id, " pass"}, 64'(pass), 64'(e.pass));
    cmp({id, " verdict"}, 64'(verdict(to, pass)), 64'(verdict(e.to, e.pass)));
  endtask
  task automatic no_expect(string id);
    checks++;
    errors++;
    $display("FAIL %s done: got 1 with no expected verdict queued", id);
  endtask
  always @(negedge clock) begin
    if (reset) seen_a = 0;
    else if (done_a && !seen_a) begin
      seen_a = 1;
      if (q_a.size() == 0) no_expect("a");
      else check_done("a", q_a.pop_front(), pass_a, to_a, exit_a, cyc_a, ins_a);
    end
    if (pass_a && !done_a) cmp("a pass before done", 64'(pass_a), 64'(0));
  end
  always @(negedge clock) begin
    if (reset) seen_b = 0;
    else if (done_b && !seen_b) begin
      seen_b = 1;
      if (q_b.size() == 0) no_expect("b");
      else check_done("b", q_b.pop_front(), pass_b, to_b, exit_b, cyc_b, ins_b);
    end
    if (pass_b && !done_b) cmp("b pass before done", 64'(pass_b), 64'(0));
  end
  always @(negedge clock) begin
    if (reset) seen_c = 0;
    else if (done_c && !seen_c) begin
      seen_c = 1;
      if (q_c.size() == 0) no_expect("c");
      else check_done("c", q_c.pop_front(), pass_c, to_c, exit_c, 64'(cyc_c), 64'(ins_c));
    end
    if (pass_c && !done_c) cmp("c pass before done", 64'(pass_c), 64'(0));
  end
  task automatic gen(int e, logic [31:0] a, bit full);
    for (int i = 0; i < 256; i++) begin
      eb_t[i] = i > e && $urandom_range(0, 7) == 0;
      a0_t[i] = $urandom;
      ret_t[i] = full || $urandom_range(0, 3) != 0;
    end
    eb_t[e] = 1;
    a0_t[e] = a;
    len = (e + 12 < 64) ? 64 : e + 12;
  endtask
  task automatic start();
    reset = 1;
    ebreak = 0;
    retire = 0;
    a0 = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask
  task automatic drive(int i);
    ebreak = eb_t[i];
    a0 = a0_t[i];
    retire = ret_t[i];
    @(posedge clock);
    #1;
  endtask
  task automatic check_zero(string tag);
    cmp({tag, " a flags"}, 64'({done_a, pass_a, to_a}), 64'(0));
    cmp({tag, " a exit"}, 64'(exit_a), 64'(0));
    cmp({tag, " a counters"}, cyc_a | ins_a, 64'(0));
    cmp({tag, " b flags"}, 64'({done_b, pass_b, to_b}), 64'(0));
    cmp({tag, " b exit"}, 64'(exit_b), 64'(0));
    cmp({tag, " b counters"}, cyc_b | ins_b, 64'(0));
    cmp({tag, " c flags"}, 64'({done_c, pass_c, to_c}), 64'(0));
    cmp({tag, " c exit"}, 64'(exit_c), 64'(0));
    cmp({tag, " c counters"}, 64'({cyc_c, ins_c}), 64'(0));
  endtask
  task automatic run();
    start();
    q_a.push_back(model(10_000_000, 2, 64));
    q_b.push_back(model(16, 2, 64));
    q_c.push_back(model(40, 0, 4));
    for (int i = 0; i < len; i++) drive(i);
    for (int w = 0; w < 100 && !(seen_a && seen_b && seen_c); w++) @(posedge clock);
    checks++;
    if (!(seen_a && seen_b && seen_c)) begin
      errors++;
      $display("FAIL run done: got %b%b%b expected 111", seen_a, seen_b, seen_c);
      q_a.delete();
      q_b.delete();
      q_c.delete();
    end
  endtask
  initial begin
    logic [31:0] a;
    reset = 1;
    repeat (2) @(posedge clock);
    #1 check_zero("initial reset");
    gen(100, 0, 1); run();
    gen(7, 1, 0); run();
    gen(15, 0, 0); run();
    gen(3, 32'd5, 0);
    start();
    for (int i = 0; i <= 3; i++) drive(i);
    cmp("abort exit capture", 64'(exit_a), 64'd5);
    cmp("abort cycles frozen", cyc_a, 64'd4);
    reset = 1;
    @(posedge clock);
    #1 check_zero("mid-drain reset");
    gen(5, 0, 0); run();
    repeat (20) begin
      a = $urandom_range(0, 1) ? 32'd0 : 32'($urandom);
      gen($urandom_range(0, 60), a, 0);
      run();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
